fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID register.
//   Owns the PC and drives the icache request (imemREN/imemaddr, completed by ihit).
//   Applies branch/jump redirects from later stages and presents the instruction, PC+4 and write/flush controls to IF/ID.
//   Stops fetching after a HALT word and counts retired fetches.
// PARAMETERS
//   PC_INIT   32'h0000_0000  PC value loaded on reset
//   HALT_WORD 32'hFFFF_FFFF  instruction encoding treated as HALT
// PORTS
//   CLK            in   1   clock, all state updates on rising edge
//   RST            in   1   synchronous reset, active-high
//   ihit           in   1   icache returns imemload for imemaddr this cycle
//   imemload       in   32  instruction word from icache
//   stall          in   1   hazard unit: hold PC and IF/ID
//   redirect_valid in   1   one-cycle pulse: branch taken / jump resolved
//   redirect_pc    in   32  target PC, valid with redirect_valid
//   imemREN        out  1   icache read enable
//   imemaddr       out  32  icache address (= PC)
//   instruction_out out 32  to IF/ID instruction_in (= imemload)
//   pcn_out        out  32  to IF/ID pcn_in (= PC+4)
//   ifid_wen       out  1   to IF/ID WEN
//   ifid_flush     out  1   to IF/ID flush (IF/ID gives flush priority over WEN)
//   fetch_count    out  32  instructions delivered to IF/ID (not flushed)
// BEHAVIOUR
//   Clock CLK; reset RST is synchronous, active-high.
//   State: PC[31:0], pend (1b), pend_pc[31:0], fsm in {RUN, HALTED}, fetch_count.
//   Reset: PC=PC_INIT, pend=0, fsm=RUN, fetch_count=0.
//   Outputs after reset: imemREN=1, imemaddr=PC_INIT, ifid_wen=0, ifid_flush=0.
//   RST mid-miss overrides everything; the in-flight request is abandoned.
//   Combinational outputs:
//     imemaddr=PC.
//     pcn_out=PC+32'd4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
//     instruction_out=imemload.
//     imemREN = (fsm==RUN).
//   Address stability: while imemREN=1 and ihit=0, PC must not change. A redirect during a miss is parked in pend/pend_pc.
//   RUN, priority high->low, evaluated per cycle:
//     1 redirect_valid & ihit   : PC<=redirect_pc; pend<=0; flush=1; wen=0.
//     2 redirect_valid & !ihit  : pend<=1; pend_pc<=redirect_pc (latest wins); flush=1; PC held.
//     3 pend & ihit             : fetched word is wrong-path; PC<=pend_pc; pend<=0; flush=1; wen=0.
//     4 ihit & stall            : wen=0, flush=0; PC held; same address re-fetched next cycle.
//     5 ihit & imemload==HALT_WORD : wen=1; PC<=PC+4; fsm<=HALTED.
//     6 ihit                    : wen=1; PC<=PC+4.
//     7 otherwise (miss)        : wen=0, flush=0; PC held.
//   Redirect overrides stall. Pend with no ihit holds until ihit (no timeout).
//   HALTED: imemREN=0; wen=0; PC held. Only redirect_valid exits:
//     PC<=redirect_pc, fsm<=RUN, flush=1 (wrong-path HALT squashed). ihit is ignored in HALTED.
//   fetch_count: +1 on every cycle with wen=1 & flush=0; wraps at 2^32.
//   Latency: one instruction per cycle at ihit=1 and stall=0; redirect target is requested the cycle after redirect_valid (case 1) or after the pending ihit (case 3).
// TESTING
//   Reset, then ihit=1 on 4 words from 0 -> imemaddr 0,4,8,C on successive cycles; wen=1 each; pcn_out 4,8,C,10; fetch_count=4.
//   ihit low 3 cycles at PC=0x20 -> imemaddr stays 0x20; wen=0; on ihit, PC->0x24.
//   Miss at 0x40; redirect_pc=0x100 pulse in miss cycle 1; ihit in cycle 3 -> flush in cycle 1 and cycle 3; wen=0 in cycle 3; next imemaddr=0x100; count unchanged.
//   redirect_valid with ihit and stall both high, redirect_pc=0x80 -> flush=1; next imemaddr=0x80 (stall ignored).
//   stall=1 for 2 cycles with ihit=1 at 0x10 -> wen=0, imemaddr=0x10 held; stall drop -> wen=1 once, PC->0x14.
//   Fetch HALT_WORD at 0x30 -> wen=1; then imemREN=0; pcn_out=0x38 held.
//   Redirect 0x200 while halted -> flush=1, imemREN=1, imemaddr=0x200.
//   PC=32'hFFFF_FFFC with ihit -> pcn_out=0; next imemaddr=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: icache request/response, hazard/redirect inputs and the IF/ID-facing outputs.
// The master side is the fetch stage; the slave side is everything around it.
interface fetch_stage_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instruction_out;
    logic [31:0] pcn_out;
    logic        ifid_wen;
    logic        ifid_flush;
    logic [31:0] fetch_count;

    modport master (
        input  ihit,
        input  imemload,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output imemREN,
        output imemaddr,
        output instruction_out,
        output pcn_out,
        output ifid_wen,
        output ifid_flush,
        output fetch_count
    );

    modport slave (
        output ihit,
        output imemload,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  imemREN,
        input  imemaddr,
        input  instruction_out,
        input  pcn_out,
        input  ifid_wen,
        input  ifid_flush,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache request, applies redirects
// (parking them while a miss is outstanding) and stops fetching after a HALT word.
module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic          CLK,
    input logic          RST,
    fetch_stage_if.master bus
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] count_q, count_d;
    logic        wen, flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StRun;
            pc_q      <= PC_INIT;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
            count_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        wen       = 1'b0;
        flush     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (bus.redirect_valid && bus.ihit) begin
                    pc_d   = bus.redirect_pc;
                    pend_d = 1'b0;
                    flush  = 1'b1;
                end else if (bus.redirect_valid) begin
                    // The miss address must stay stable, so the target waits for the ihit.
                    pend_d    = 1'b1;
                    pend_pc_d = bus.redirect_pc;
                    flush     = 1'b1;
                end else if (pend_q && bus.ihit) begin
                    pc_d   = pend_pc_q;
                    pend_d = 1'b0;
                    flush  = 1'b1;
                end else if (bus.ihit && !bus.stall) begin
                    wen  = 1'b1;
                    pc_d = pc_q + 32'd4;
                    if (bus.imemload == HALT_WORD) begin
                        state_d = StHalted;
                    end
                end
            end
            StHalted: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    pend_d  = 1'b0;
                    state_d = StRun;
                    flush   = 1'b1;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        count_d = (wen && !flush) ? count_q + 32'd1 : count_q;
    end

    assign bus.imemREN         = (state_q == StRun);
    assign bus.imemaddr        = pc_q;
    assign bus.pcn_out         = pc_q + 32'd4;
    assign bus.instruction_out = bus.imemload;
    assign bus.ifid_wen        = wen;
    assign bus.ifid_flush      = flush;
    assign bus.fetch_count     = count_q;

endmodule
